// File: rtl/nvm_ctrl_pkg.sv
// Shared types for the NVM serial controller: scheduler states, byte-path owner
// encoding and the default byte width.
package nvm_ctrl_pkg;

  localparam int unsigned NVM_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CMD,
    OWN_DAT
  } own_e;

endpackage

// File: rtl/nvm_piso_arb.sv
// Frame arbiter for the shared PISO: cmd has priority, but dat is served once cmd
// has won MAX_CMD_RUN consecutive frames while dat was waiting.
module nvm_piso_arb
  import nvm_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CMD_RUN = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic cmd_req,
  input  logic dat_req,
  input  logic grant_en,
  output own_e owner
);

  localparam int unsigned RW = (MAX_CMD_RUN > 0) ? $clog2(MAX_CMD_RUN + 1) : 1;

  logic [RW-1:0] cmd_run_q;
  logic [RW-1:0] cmd_run_d;
  logic          starved;

  always_comb begin
    starved = (cmd_run_q == RW'(MAX_CMD_RUN));
    owner   = OWN_NONE;
    if (cmd_req && !(dat_req && starved)) begin
      owner = OWN_CMD;
    end else if (dat_req) begin
      owner = OWN_DAT;
    end
  end

  // The run only grows while dat is actually waiting; any uncontended cmd grant resets it.
  always_comb begin
    cmd_run_d = cmd_run_q;
    if (grant_en) begin
      case (owner)
        OWN_CMD: begin
          if (!dat_req) begin
            cmd_run_d = '0;
          end else if (!starved) begin
            cmd_run_d = cmd_run_q + 1'b1;
          end
        end
        OWN_DAT: cmd_run_d = '0;
        default: cmd_run_d = cmd_run_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cmd_run_q <= '0;
    end else begin
      cmd_run_q <= cmd_run_d;
    end
  end

endmodule

// File: rtl/nvm_piso_sched.sv
// Shares one PISO serialiser between the cmd and dat byte sources: arbitrates whole
// frames, sequences load/shift per byte and frames the link with cs_n.
module nvm_piso_sched
  import nvm_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = NVM_BYTE_W,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_CMD_RUN = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_req,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_last,
  output logic             cmd_gnt,
  input  logic             dat_req,
  input  logic [WIDTH-1:0] dat_data,
  input  logic             dat_last,
  output logic             dat_gnt,
  input  logic             abort,
  output logic [WIDTH-1:0] PISO_D,
  output logic             PISO_Load,
  output logic             PISO_Read,
  output logic             cs_n,
  output logic             busy,
  output logic             byte_done,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  own_e             owner_q, owner_d;
  own_e             arb_owner;
  logic             last_q, last_d;
  logic [WIDTH-1:0] piso_d_q, piso_d_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             byte_done_q, byte_done_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             grant_en;
  logic             own_req;
  logic [WIDTH-1:0] own_data;
  logic             own_last;

  nvm_piso_arb #(
    .MAX_CMD_RUN(MAX_CMD_RUN)
  ) u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .cmd_req  (cmd_req),
    .dat_req  (dat_req),
    .grant_en (grant_en),
    .owner    (arb_owner)
  );

  always_comb begin
    grant_en = (state_q == IDLE) && (cmd_req || dat_req);
    own_req  = 1'b0;
    own_data = cmd_data;
    own_last = cmd_last;
    case (owner_q)
      OWN_CMD: own_req = cmd_req;
      OWN_DAT: begin
        own_req  = dat_req;
        own_data = dat_data;
        own_last = dat_last;
      end
      default: own_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    piso_d_d     = piso_d_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    byte_done_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    if (abort && (state_q == LOAD || state_q == SHIFT || state_q == HOLD)) begin
      state_d     = GAP;
      owner_d     = OWN_NONE;
      bit_cnt_d   = '0;
      gap_cnt_d   = '0;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            owner_d  = arb_owner;
            piso_d_d = (arb_owner == OWN_DAT) ? dat_data : cmd_data;
            last_d   = (arb_owner == OWN_DAT) ? dat_last : cmd_last;
            state_d  = LOAD;
          end
        end
        LOAD: begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt_q == BCW'(WIDTH - 1)) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
            if (last_q) begin
              state_d      = GAP;
              owner_d      = OWN_NONE;
              gap_cnt_d    = '0;
              frame_done_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (own_req) begin
            piso_d_d = own_data;
            last_d   = own_last;
            state_d  = LOAD;
          end
        end
        GAP: begin
          if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    PISO_D     = piso_d_q;
    PISO_Load  = (state_q == LOAD);
    PISO_Read  = (state_q == SHIFT);
    cs_n       = !(state_q == LOAD || state_q == SHIFT || state_q == HOLD);
    busy       = (state_q != IDLE);
    cmd_gnt    = (state_q == LOAD) && (owner_q == OWN_CMD);
    dat_gnt    = (state_q == LOAD) && (owner_q == OWN_DAT);
    byte_done  = byte_done_q;
    frame_done = frame_done_q;
    frame_err  = frame_err_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      last_q       <= 1'b0;
      piso_d_q     <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      byte_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      piso_d_q     <= piso_d_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      byte_done_q  <= byte_done_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_nvm_piso_sched.sv
// Directed bench for nvm_piso_sched: per-cycle output vectors against hand-derived
// expectations for each scheduling scenario.
module tb_nvm_piso_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cmd_req = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_last = 1'b0;
  logic       cmd_gnt;
  logic       dat_req = 1'b0;
  logic [7:0] dat_data = 8'h00;
  logic       dat_last = 1'b0;
  logic       dat_gnt;
  logic       abort = 1'b0;
  logic [7:0] PISO_D;
  logic       PISO_Load, PISO_Read, cs_n, busy, byte_done, frame_done, frame_err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // {Load, Read, cs_n, busy, byte_done, frame_done, frame_err, cmd_gnt, dat_gnt}
  logic [8:0] obs;
  assign obs = {PISO_Load, PISO_Read, cs_n, busy, byte_done, frame_done, frame_err, cmd_gnt, dat_gnt};

  localparam logic [8:0] E_IDLE   = 9'b0_0_1_0_0_0_0_0_0;
  localparam logic [8:0] E_LOADC  = 9'b1_0_0_1_0_0_0_1_0;
  localparam logic [8:0] E_LOADD  = 9'b1_0_0_1_0_0_0_0_1;
  localparam logic [8:0] E_SHIFT  = 9'b0_1_0_1_0_0_0_0_0;
  localparam logic [8:0] E_HOLD   = 9'b0_0_0_1_0_0_0_0_0;
  localparam logic [8:0] E_HOLDBD = 9'b0_0_0_1_1_0_0_0_0;
  localparam logic [8:0] E_GAPFD  = 9'b0_0_1_1_1_1_0_0_0;
  localparam logic [8:0] E_GAP    = 9'b0_0_1_1_0_0_0_0_0;
  localparam logic [8:0] E_GAPERR = 9'b0_0_1_1_0_0_1_0_0;

  nvm_piso_sched #(
    .WIDTH      (8),
    .GAP_CYCLES (2),
    .MAX_CMD_RUN(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_req   (cmd_req),
    .cmd_data  (cmd_data),
    .cmd_last  (cmd_last),
    .cmd_gnt   (cmd_gnt),
    .dat_req   (dat_req),
    .dat_data  (dat_data),
    .dat_last  (dat_last),
    .dat_gnt   (dat_gnt),
    .abort     (abort),
    .PISO_D    (PISO_D),
    .PISO_Load (PISO_Load),
    .PISO_Read (PISO_Read),
    .cs_n      (cs_n),
    .busy      (busy),
    .byte_done (byte_done),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    cmd_req = 1'b1;
    dat_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({obs, PISO_D} !== {E_IDLE, 8'h00}) $display("FAIL reset_hold[%0d]: got %b/%h want %b/00", i, obs, PISO_D, E_IDLE);
      else n_pass++;
    end
    cmd_req = 1'b0;
    dat_req = 1'b0;
    RST = 1'b1;
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_IDLE, 8'h00}) $display("FAIL reset_release: got %b/%h want %b/00", obs, PISO_D, E_IDLE);
    else n_pass++;
  endtask

  task automatic test_single_cmd();
    cmd_req = 1'b1; cmd_data = 8'hA5; cmd_last = 1'b1;
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_LOADC, 8'hA5}) $display("FAIL single_load: got %b/%h want %b/a5", obs, PISO_D, E_LOADC);
    else n_pass++;
    cmd_req = 1'b0; cmd_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if ({obs, PISO_D} !== {E_SHIFT, 8'hA5}) $display("FAIL single_shift[%0d]: got %b/%h want %b/a5", i, obs, PISO_D, E_SHIFT);
      else n_pass++;
    end
    tick();
    n_total++;
    if (obs !== E_GAPFD) $display("FAIL single_done: got %b want %b", obs, E_GAPFD);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== E_GAP) $display("FAIL single_gap2: got %b want %b", obs, E_GAP);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== E_IDLE) $display("FAIL single_idle: got %b want %b", obs, E_IDLE);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  f0 [3] = '{8'h03, 8'h00, 8'h10};
    int unsigned nb;
    logic [7:0]  exp_d;
    cmd_req = 1'b1; cmd_data = 8'h03; cmd_last = 1'b0;
    dat_req = 1'b1; dat_data = 8'h5C; dat_last = 1'b1;
    for (int unsigned f = 0; f < 4; f++) begin
      nb = (f == 0) ? 3 : 1;
      for (int unsigned b = 0; b < nb; b++) begin
        exp_d = (f == 0) ? f0[b] : 8'(8'hC0 + f);
        tick();
        n_total++;
        if ({obs, PISO_D} !== {E_LOADC, exp_d}) $display("FAIL b2b_load f%0d b%0d: got %b/%h want %b/%h", f, b, obs, PISO_D, E_LOADC, exp_d);
        else n_pass++;
        if (b + 1 < nb) begin
          cmd_data = f0[b+1];
          cmd_last = (b + 2 == nb);
        end else begin
          cmd_data = 8'(8'hC1 + f);
          cmd_last = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          tick();
          n_total++;
          if ({obs, PISO_D} !== {E_SHIFT, exp_d}) $display("FAIL b2b_shift f%0d b%0d[%0d]: got %b/%h want %b/%h", f, b, i, obs, PISO_D, E_SHIFT, exp_d);
          else n_pass++;
        end
        tick();
        n_total++;
        if (obs !== ((b + 1 < nb) ? E_HOLDBD : E_GAPFD)) $display("FAIL b2b_bdone f%0d b%0d: got %b", f, b, obs);
        else n_pass++;
      end
      tick();
      n_total++;
      if (obs !== E_GAP) $display("FAIL b2b_gap2 f%0d: got %b want %b", f, obs, E_GAP);
      else n_pass++;
      tick();
      n_total++;
      if (obs !== E_IDLE) $display("FAIL b2b_idle f%0d: got %b want %b", f, obs, E_IDLE);
      else n_pass++;
    end
    // Fifth contended arbitration: cmd has used its run, dat must win.
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_LOADD, 8'h5C}) $display("FAIL b2b_dat_wins: got %b/%h want %b/5c", obs, PISO_D, E_LOADD);
    else n_pass++;
    cmd_req = 1'b0;
    dat_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if ({obs, PISO_D} !== {E_SHIFT, 8'h5C}) $display("FAIL b2b_dshift[%0d]: got %b/%h want %b/5c", i, obs, PISO_D, E_SHIFT);
      else n_pass++;
    end
    tick();
    n_total++;
    if (obs !== E_GAPFD) $display("FAIL b2b_ddone: got %b want %b", obs, E_GAPFD);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (obs !== E_IDLE) $display("FAIL b2b_didle: got %b want %b", obs, E_IDLE);
    else n_pass++;
  endtask

  task automatic test_both_same_cycle();
    cmd_req = 1'b1; cmd_data = 8'h11; cmd_last = 1'b1;
    dat_req = 1'b1; dat_data = 8'h22; dat_last = 1'b1;
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_LOADC, 8'h11}) $display("FAIL both_load: got %b/%h want %b/11", obs, PISO_D, E_LOADC);
    else n_pass++;
    cmd_req = 1'b0;
    dat_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if (obs !== E_SHIFT) $display("FAIL both_shift[%0d]: got %b want %b", i, obs, E_SHIFT);
      else n_pass++;
    end
    tick();
    n_total++;
    if (obs !== E_GAPFD) $display("FAIL both_done: got %b want %b", obs, E_GAPFD);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (obs !== E_IDLE) $display("FAIL both_idle: got %b want %b", obs, E_IDLE);
    else n_pass++;
  endtask

  task automatic test_hold();
    dat_req = 1'b1; dat_data = 8'h96; dat_last = 1'b0;
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_LOADD, 8'h96}) $display("FAIL hold_load: got %b/%h want %b/96", obs, PISO_D, E_LOADD);
    else n_pass++;
    dat_req = 1'b0;
    cmd_req = 1'b1; cmd_data = 8'hEE; cmd_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if ({obs, PISO_D} !== {E_SHIFT, 8'h96}) $display("FAIL hold_shift[%0d]: got %b/%h want %b/96", i, obs, PISO_D, E_SHIFT);
      else n_pass++;
    end
    tick();
    n_total++;
    if (obs !== E_HOLDBD) $display("FAIL hold_bdone: got %b want %b", obs, E_HOLDBD);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if (obs !== E_HOLD) $display("FAIL hold_wait[%0d]: got %b want %b", i, obs, E_HOLD);
      else n_pass++;
    end
    cmd_req = 1'b0;
    dat_req = 1'b1; dat_data = 8'h69; dat_last = 1'b1;
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_LOADD, 8'h69}) $display("FAIL hold_resume: got %b/%h want %b/69", obs, PISO_D, E_LOADD);
    else n_pass++;
    dat_req = 1'b0;
    repeat (8) tick();
    tick();
    n_total++;
    if (obs !== E_GAPFD) $display("FAIL hold_done: got %b want %b", obs, E_GAPFD);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (obs !== E_IDLE) $display("FAIL hold_idle: got %b want %b", obs, E_IDLE);
    else n_pass++;
  endtask

  task automatic test_abort();
    abort = 1'b1;
    tick();
    n_total++;
    if (obs !== E_IDLE) $display("FAIL abort_in_idle: got %b want %b", obs, E_IDLE);
    else n_pass++;
    abort = 1'b0;
    cmd_req = 1'b1; cmd_data = 8'h3C; cmd_last = 1'b1;
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_LOADC, 8'h3C}) $display("FAIL abort_load: got %b/%h want %b/3c", obs, PISO_D, E_LOADC);
    else n_pass++;
    cmd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (obs !== E_SHIFT) $display("FAIL abort_shift[%0d]: got %b want %b", i, obs, E_SHIFT);
      else n_pass++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++;
    if (obs !== E_GAPERR) $display("FAIL abort_err: got %b want %b", obs, E_GAPERR);
    else n_pass++;
    tick();
    n_total++;
    if (obs !== E_GAP) $display("FAIL abort_gap2: got %b want %b", obs, E_GAP);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (obs !== E_IDLE) $display("FAIL abort_idle[%0d]: got %b want %b", i, obs, E_IDLE);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    cmd_req = 1'b1; cmd_last = 1'b1;
    dat_req = 1'b1; dat_data = 8'h77; dat_last = 1'b1;
    for (int unsigned f = 0; f < 4; f++) begin
      cmd_data = 8'(8'hD0 + f);
      tick();
      n_total++;
      if ({obs, PISO_D} !== {E_LOADC, 8'(8'hD0 + f)}) $display("FAIL rmid_load f%0d: got %b/%h want %b/%h", f, obs, PISO_D, E_LOADC, 8'(8'hD0 + f));
      else n_pass++;
      if (f < 3) repeat (11) tick();
    end
    repeat (3) tick();
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({obs, PISO_D} !== {E_IDLE, 8'h00}) $display("FAIL rmid_reset[%0d]: got %b/%h want %b/00", i, obs, PISO_D, E_IDLE);
      else n_pass++;
    end
    RST = 1'b1;
    cmd_data = 8'hE7;
    tick();
    n_total++;
    if ({obs, PISO_D} !== {E_LOADC, 8'hE7}) $display("FAIL rmid_run_cleared: got %b/%h want %b/e7", obs, PISO_D, E_LOADC);
    else n_pass++;
    cmd_req = 1'b0;
    dat_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if ({obs, PISO_D} !== {E_SHIFT, 8'hE7}) $display("FAIL rmid_shift[%0d]: got %b/%h want %b/e7", i, obs, PISO_D, E_SHIFT);
      else n_pass++;
    end
    tick();
    n_total++;
    if (obs !== E_GAPFD) $display("FAIL rmid_done: got %b want %b", obs, E_GAPFD);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (obs !== E_IDLE) $display("FAIL rmid_idle: got %b want %b", obs, E_IDLE);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_back_to_back();
    test_both_same_cycle();
    test_hold();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nvm_piso_sched.md
Name: nvm_piso_sched

Overview:
- Scheduler that shares the single 8-bit PISO serialiser between two byte sources: the command/address path (cmd) and the write-data path (dat).
- Arbitrates whole frames, then sequences the PISO for each byte: load pulse, then WIDTH shift-enable cycles.
- Frames the serial link with an active-low chip select and reports byte and frame completion.
- Sits between the NVM access FSM (requesters) and the PISO.

Parameters:
- WIDTH, 8: bits per byte; sets PISO_D width and shift count.
- GAP_CYCLES, 2: chip-select-high cycles after each frame; range 1..15.
- MAX_CMD_RUN, 4: maximum consecutive cmd frames granted while dat is waiting.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-low.
- cmd_req  in  1  cmd has a byte ready.
- cmd_data  in  WIDTH  cmd byte.
- cmd_last  in  1  byte is last of cmd frame.
- cmd_gnt  out  1  one-cycle pulse: cmd byte accepted.
- dat_req, dat_data, dat_last, dat_gnt: same as cmd_*, for dat.
- abort  in  1  kill current frame.
- PISO_D  out  WIDTH  byte to PISO parallel input.
- PISO_Load  out  1  one-cycle load strobe.
- PISO_Read  out  1  shift enable, one bit per cycle, MSB first.
- cs_n  out  1  frame select, low during a frame.
- busy  out  1  state != IDLE.
- byte_done  out  1  one-cycle pulse after a byte's last shift.
- frame_done  out  1  one-cycle pulse on normal frame end.
- frame_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset: state IDLE; owner none; bit counter, gap counter and cmd_run cleared.
  - Reset values: PISO_D=0, PISO_Load=0, PISO_Read=0, cs_n=1, all gnt/done/err=0, busy=0.
  - Reset mid-frame takes effect at the next edge; no completion pulses are emitted.
- States: IDLE, LOAD, SHIFT, HOLD, GAP.
- IDLE, at an edge with any req:
  - Pick owner.
  - Register owner data into PISO_D.
  - Go to LOAD.
- Arbitration (IDLE only):
  - Only cmd_req: cmd wins. Only dat_req: dat wins.
  - Both: cmd wins, unless cmd_run==MAX_CMD_RUN, in which case dat wins.
  - cmd_run update:
    - +1 on a cmd grant with dat_req=1 (saturating).
    - Cleared on a cmd grant with dat_req=0.
    - Cleared on a dat grant.
  - Frames are never interleaved; the owner is locked until its last byte or abort.
- LOAD (exactly 1 cycle):
  - PISO_Load=1, owner gnt=1, cs_n=0.
  - Owner must change data/last or drop req before the next edge.
  - The last flag is registered at this edge.
  - Next state: SHIFT.
- SHIFT (exactly WIDTH cycles):
  - PISO_Read=1, cs_n=0, PISO_D held.
  - Bit counter counts 0..WIDTH-1.
  - After the final count: go to GAP if the registered last=1, else HOLD.
  - byte_done=1 in the first cycle after SHIFT.
- HOLD:
  - cs_n=0, PISO_Read=0.
  - Waits indefinitely for owner req; the non-owner req is ignored.
  - Owner req at an edge: register data, go to LOAD.
- GAP:
  - cs_n=1 for GAP_CYCLES cycles, then IDLE.
  - frame_done=1 in the first GAP cycle on normal entry.
- Latencies:
  - req seen at edge k: Load/gnt during cycle k+1.
  - Shifting during k+2..k+1+WIDTH.
  - Minimum byte-to-byte spacing inside a frame: WIDTH+2 cycles.
- abort=1 at an edge:
  - In LOAD, SHIFT or HOLD: go to GAP, PISO_Read=0, frame_err=1 for 1 cycle, no frame_done, owner cleared.
  - In IDLE or GAP: ignored.
  - Abort beats req at the same edge.
- Priority at the same edge: reset > abort > normal transitions.
- gnt is never asserted outside LOAD; at most one gnt is high per cycle.

Decomposition:
- Package nvm_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, HOLD, GAP);
  - the owner encoding (OWN_NONE, OWN_CMD, OWN_DAT);
  - the default byte width constant 8.
- One sub-module, nvm_piso_arb:
  - combinational owner select plus registered cmd_run starvation counter;
  - ports: cmd_req, dat_req, grant_en, owner, CLK, RST.
- The FSM, bit counter and gap counter stay in nvm_piso_sched.

Test Plan:
- Single cmd byte 0xA5, last=1, at edge 3 → cmd_gnt and PISO_Load in cycle 4; PISO_Read high cycles 5..12; byte_done and frame_done at cycle 13; cs_n high cycles 13..14; busy low from cycle 15.
- cmd 3-byte frame 0x03,0x00,0x10 with dat_req asserted throughout → no dat_gnt until cmd's frame_done; then dat wins only after 4 consecutive cmd frames (with cmd_req held high).
- Both req asserted in the same cycle from IDLE, cmd_run=0 → cmd_gnt only, dat_gnt stays 0 that cycle.
- dat frame, owner req dropped in HOLD for 10 cycles → cs_n stays 0, PISO_Read 0, and no cmd_gnt even with cmd_req=1.
- abort pulsed at the 4th SHIFT cycle → PISO_Read 0 at next cycle, frame_err pulse, cs_n high for 2 cycles, no frame_done, then IDLE.
- RST driven low during SHIFT → at the next edge all outputs return to reset values; after release, a new cmd request completes normally with cmd_run=0.
